rv32i_core: RTL and testbench
=============================

Name: rv32i_core

Overview:
- Minimal multi-cycle RV32I integer core: fetches each instruction over a valid/ready request/response instruction-memory port, then executes it and writes back.
- Sits between the clock/reset infrastructure and the shared memory model. There is no data-memory port.
- Architectural state is the PC and 32 x 32-bit registers. Verification reads the register file hierarchically as array `regs[0:31]`.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low. Single clock domain.
- imem_req_vld  out  1  fetch request valid.
- imem_req_rdy  in  1  memory accepts the request.
- imem_req  out  mem_pkt_t  fetch packet.
- imem_rsp_vld  in  1  response valid.
- imem_rsp_rdy  out  1  core accepts the response.
- imem_rsp  in  mem_pkt_t  response packet; .data carries the instruction.

Behaviour:
- mem_pkt_t (packed, 65 bits) = {op: 1 bit, 0=READ, 1=WRITE; addr: 32-bit byte address; data: 32 bits}.
- Request packet is always {READ, pc, 32'h0}.
- FSM has two states, FETCH and WAIT.
- FETCH:
  - imem_req_vld=1, imem_rsp_rdy=0.
  - On vld&&rdy, go to WAIT.
  - Request fields stay stable while vld is high and rdy is low.
- WAIT:
  - imem_req_vld=0, imem_rsp_rdy=1.
  - On imem_rsp_vld, decode and execute combinationally from imem_rsp.data in that cycle.
  - At that clock edge: update the register file and PC, then return to FETCH.
- Minimum cost is 2 cycles per instruction; memory stalls extend either state indefinitely.
- A response arriving while in FETCH is not accepted (rsp_rdy=0). Only one request is outstanding at a time.
- Reset (any time, including mid-handshake):
  - State=FETCH, pc=RESET_PC, all regs=0.
  - imem_req_vld asserts in the first cycle after rst_n deasserts, and imem_rsp_rdy=0.
  - An in-flight response is discarded.
- Outputs while rst_n=0: imem_req_vld=0, imem_rsp_rdy=0, imem_req=0.
- x0 reads as 0; writes to x0 are dropped.
- Supported instructions:
  - LUI, AUIPC.
  - JAL, JALR (rd=pc+4).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Arithmetic and width rules:
  - All arithmetic is modulo 2^32; there is no overflow trap.
  - Shift amount is the low 5 bits.
  - Immediates are sign-extended per the I/S/B/U/J formats.
- Next PC:
  - Taken branch: pc+immB. JAL: pc+immJ. JALR: (rs1+immI).
  - Otherwise pc+4.
  - Next PC has bits [1:0] forced to 00; there are no misalignment exceptions.
- Instructions executed as NOPs (no register write, pc+4): loads, stores, FENCE, SYSTEM, and all illegal encodings.
- When JAL/JALR has rd=rs1, the link write uses the pre-update rs1 value for the target.
- PC wraps from 0xFFFF_FFFC to 0x0000_0000.

Decomposition:
- memory_types_pkg (shared): mem_pkt_t and the mem_op_e enum {MEM_READ, MEM_WRITE}.
- rv32i_pkg: opcode, funct3 and funct7 localparams; alu_op_e enum.
- One sub-module, rv32i_alu: combinational, inputs a, b, alu_op_e, output result.
- Branch compare lives in the core.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release.
  - Required: first request is {READ, 0x0, 0}; req_vld stays high until rdy.
  - Required: regs all 0.
- ALU sequence: 0x00500093 (addi x1,x0,5), 0xFFD00113 (addi x2,x0,-3), 0x002081B3 (add x3,x1,x2), 0x12345237 (lui x4,0x12345).
  - Required: x1=5, x2=0xFFFFFFFD, x3=2, x4=0x12345000.
  - Required: fetch addresses 0,4,8,12.
- Branch: 0x00000463 (beq x0,x0,+8) at pc 0x10.
  - Required: next fetch address 0x18.
  - Required: bne with equal operands fetches 0x14.
- Jump: 0x010002EF (jal x5,+16) at pc 0x20.
  - Required: x5=0x24, next fetch address 0x30.
  - Required: JALR to odd target 0x41 fetches 0x40.
- Stalls: memory holds req_rdy=0 for 5 cycles, then rsp_vld=0 for 4 cycles.
  - Required: request fields stable throughout; exactly one instruction retired; no duplicate request.
- Edge cases:
  - Required: addi x0,x0,7 leaves x0=0.
  - Required: a load/store encoding retires as a NOP with pc+4.
  - Reset asserted while in WAIT; required: a response then ignored, fetch restarts at 0x0.

Source files
------------

// File: rtl/memory_types_pkg.sv
// Packet and operation types shared by every agent on the memory model.
package memory_types_pkg;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_e;

    typedef struct packed {
        mem_op_e     op;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_pkt_t;

endpackage

// File: rtl/rv32i_pkg.sv
// RV32I encoding constants, ALU operation set and core sequencing states.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_WAIT  = 1'b1
    } core_state_e;

    // alt selects SUB/SRA in the two funct3 slots that carry a variant
    function automatic alu_op_e alu_op_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD_SUB: alu_op_decode = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     alu_op_decode = ALU_SLL;
            F3_SLT:     alu_op_decode = ALU_SLT;
            F3_SLTU:    alu_op_decode = ALU_SLTU;
            F3_XOR:     alu_op_decode = ALU_XOR;
            F3_SRL_SRA: alu_op_decode = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      alu_op_decode = ALU_OR;
            default:    alu_op_decode = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_alu.sv
// Combinational 32-bit integer ALU; shifts use the low five bits of b.
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_core.sv
// Multi-cycle RV32I integer core: one fetch handshake, then execute and
// write back in the cycle the instruction response is accepted.
//
// state    | meaning
// ST_FETCH | request {READ, pc, 0} offered until the memory accepts it
// ST_WAIT  | waiting for the instruction; executes and retires on rsp_vld
module rv32i_core
    import memory_types_pkg::*;
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic     clk,
    input  logic     rst_n,
    output logic     imem_req_vld,
    input  logic     imem_req_rdy,
    output mem_pkt_t imem_req,
    input  logic     imem_rsp_vld,
    output logic     imem_rsp_rdy,
    input  mem_pkt_t imem_rsp
);

    core_state_e state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] regs [0:31];

    logic [31:0] inst;
    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] rs1_val, rs2_val, pc_plus4;
    logic [31:0] imm_i, imm_b, imm_u, imm_j;

    assign inst   = imem_rsp.data;
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign f3     = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign f7     = inst[31:25];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // x0 is never written, so reading it always yields zero
    assign rs1_val  = regs[rs1];
    assign rs2_val  = regs[rs2];
    assign pc_plus4 = pc_q + 32'd4;

    logic rsp_unused;
    assign rsp_unused = ^{imem_rsp.op, imem_rsp.addr};

    logic        branch_taken;
    always_comb begin
        branch_taken = 1'b0;
        case (f3)
            F3_BEQ:  branch_taken = (rs1_val == rs2_val);
            F3_BNE:  branch_taken = (rs1_val != rs2_val);
            F3_BLT:  branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: branch_taken = (rs1_val <  rs2_val);
            F3_BGEU: branch_taken = (rs1_val >= rs2_val);
            default: branch_taken = 1'b0;
        endcase
    end

    alu_op_e     alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        rd_we, use_link;
    logic [31:0] next_pc_raw, next_pc, wr_data;

    always_comb begin
        alu_op      = ALU_ADD;
        alu_a       = rs1_val;
        alu_b       = imm_i;
        rd_we       = 1'b0;
        use_link    = 1'b0;
        next_pc_raw = pc_plus4;
        case (opcode)
            OPC_LUI: begin
                alu_a = '0;
                alu_b = imm_u;
                rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                alu_a = pc_q;
                alu_b = imm_u;
                rd_we = 1'b1;
            end
            OPC_JAL: begin
                rd_we       = 1'b1;
                use_link    = 1'b1;
                next_pc_raw = pc_q + imm_j;
            end
            OPC_JALR: begin
                if (f3 == F3_JALR) begin
                    rd_we       = 1'b1;
                    use_link    = 1'b1;
                    next_pc_raw = alu_result;
                end
            end
            OPC_BRANCH: begin
                if (branch_taken) next_pc_raw = pc_q + imm_b;
            end
            OPC_OP_IMM: begin
                alu_op = alu_op_decode(f3, (f3 == F3_SRL_SRA) && (f7 == F7_ALT));
                rd_we  = 1'b1;
                if (f3 == F3_SLL && f7 != F7_BASE) rd_we = 1'b0;
                if (f3 == F3_SRL_SRA && f7 != F7_BASE && f7 != F7_ALT) rd_we = 1'b0;
            end
            OPC_OP: begin
                alu_b  = rs2_val;
                alu_op = alu_op_decode(f3, f7 == F7_ALT);
                rd_we  = (f7 == F7_BASE) ||
                         ((f7 == F7_ALT) && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA));
            end
            default: ;
        endcase
    end

    rv32i_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result)
    );

    assign wr_data = use_link ? pc_plus4 : alu_result;
    assign next_pc = {next_pc_raw[31:2], 2'b00};

    logic retire, req_vld_int, rsp_rdy_int;
    assign retire = (state_q == ST_WAIT) && imem_rsp_vld;

    always_comb begin
        state_d     = state_q;
        req_vld_int = 1'b0;
        rsp_rdy_int = 1'b0;
        case (state_q)
            ST_FETCH: begin
                req_vld_int = 1'b1;
                if (imem_req_rdy) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                rsp_rdy_int = 1'b1;
                if (imem_rsp_vld) state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // outputs are forced quiet for as long as reset is held
    assign imem_req_vld = req_vld_int & rst_n;
    assign imem_rsp_rdy = rsp_rdy_int & rst_n;

    always_comb begin
        imem_req = '0;
        if (rst_n) begin
            imem_req.op   = MEM_READ;
            imem_req.addr = pc_q;
            imem_req.data = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            if (retire) pc_q <= next_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (retire && rd_we && rd != 5'd0) begin
            regs[rd] <= wr_data;
        end
    end

endmodule

// File: tb/tb_rv32i_core.sv
// Scoreboard bench for rv32i_core: an instruction-level reference model predicts
// each next fetch address and register result; a monitor checks them at fetch.
module tb_rv32i_core;
    import memory_types_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     imem_req_vld, imem_req_rdy, imem_rsp_vld, imem_rsp_rdy;
    mem_pkt_t imem_req, imem_rsp;

    always #5 clk = ~clk;

    rv32i_core #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req_vld (imem_req_vld),
        .imem_req_rdy (imem_req_rdy),
        .imem_req     (imem_req),
        .imem_rsp_vld (imem_rsp_vld),
        .imem_rsp_rdy (imem_rsp_rdy),
        .imem_rsp     (imem_rsp)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        bit          chk;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no handshake within bound", name);
        finish_sim();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc = 32'h0;
        exp_q.delete();
        exp_q.push_back('{32'h0, 1'b0, 5'd0, 32'h0});
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input bit alt,
                                            input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic bit br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_exec(input logic [31:0] ins);
        logic [6:0]  opc, f7;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] a, b, i_imm, b_imm, u_imm, j_imm, npc, res;
        bit          wr;
        opc = ins[6:0];  rd = ins[11:7]; f3 = ins[14:12];
        rs1 = ins[19:15]; rs2 = ins[24:20]; f7 = ins[31:25];
        i_imm = {{20{ins[31]}}, ins[31:20]};
        b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        u_imm = {ins[31:12], 12'b0};
        j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        a = m_regs[rs1]; b = m_regs[rs2];
        npc = m_pc + 32'd4; wr = 1'b0; res = '0;
        case (opc)
            7'h37: begin res = u_imm; wr = 1'b1; end
            7'h17: begin res = m_pc + u_imm; wr = 1'b1; end
            7'h6F: begin res = m_pc + 32'd4; wr = 1'b1; npc = m_pc + j_imm; end
            7'h67: if (f3 == 3'd0) begin res = m_pc + 32'd4; wr = 1'b1; npc = a + i_imm; end
            7'h63: if (br_ref(f3, a, b)) npc = m_pc + b_imm;
            7'h13: begin
                if (!((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))) begin
                    res = alu_ref(f3, (f3 == 3'd5) && (f7 == 7'h20), a, i_imm);
                    wr  = 1'b1;
                end
            end
            7'h33: begin
                if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                    res = alu_ref(f3, f7 == 7'h20, a, b);
                    wr  = 1'b1;
                end
            end
            default: ;
        endcase
        npc[1:0] = 2'b00;
        if (wr && rd != 5'd0) m_regs[rd] = res;
        m_pc = npc;
        exp_q.push_back('{npc, 1'b1, rd, m_regs[rd]});
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [6:0]  sys_opc [4];
        int          kind;
        sys_opc = '{7'h03, 7'h23, 7'h0F, 7'h73};
        r    = $urandom;
        rd   = 5'($urandom_range(0, 7));
        rs1  = 5'($urandom_range(0, 7));
        rs2  = 5'($urandom_range(0, 7));
        f3   = 3'($urandom_range(0, 7));
        kind = int'($urandom_range(0, 11));
        case (kind)
            0: return {r[31:12], rd, 7'h37};
            1: return {r[31:12], rd, 7'h17};
            2: return {r[31:12], rd, 7'h6F};
            3: return {r[31:20], rs1, 3'b000, rd, 7'h67};
            4: return {r[31:25], rs2, rs1, f3, r[11:7], 7'h63};
            5, 6: begin
                f7 = r[31:25];
                if ((f3 == 3'd1 || f3 == 3'd5) && r[0]) f7 = r[1] ? 7'h20 : 7'h00;
                return {f7, r[24:20], rs1, f3, rd, 7'h13};
            end
            7, 8: begin
                f7 = (r[2:0] == 3'd0) ? r[31:25] : (r[3] ? 7'h20 : 7'h00);
                return {f7, rs2, rs1, f3, rd, 7'h33};
            end
            9:  return r;
            10: return {r[31:15], f3, rd, sys_opc[r[1:0]]};
            default: return {r[31:20], rs1, f3, rd, 7'h13};
        endcase
    endfunction

    // Monitor: one expectation is consumed per accepted fetch request
    mem_pkt_t prev_req;
    bit       prev_stall = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check32("req_vld_held", {31'b0, imem_req_vld}, 32'd1);
                checks++;
                if (imem_req !== prev_req) begin
                    errors++;
                    $display("FAIL req_stable: got %h expected %h", imem_req, prev_req);
                end
            end
            if (imem_req_vld && imem_req_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_request: got addr %08h expected none", imem_req.addr);
                end else begin
                    e = exp_q.pop_front();
                    check32("fetch_addr", imem_req.addr, e.addr);
                    check32("req_data", imem_req.data, 32'h0);
                    check32("req_op", {31'b0, imem_req.op == MEM_WRITE}, 32'd0);
                    if (e.chk) check32($sformatf("reg_x%0d", e.rd), dut.regs[e.rd], e.val);
                end
            end
            prev_stall = imem_req_vld && !imem_req_rdy;
            prev_req   = imem_req;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req_vld && n < 50) begin
            tick();
            n++;
        end
        if (!imem_req_vld) timeout("req_vld_wait");
    endtask

    task automatic do_txn(input logic [31:0] ins, input int req_dly, input int rsp_dly);
        wait_req();
        repeat (req_dly) tick();
        imem_req_rdy = 1'b1;
        tick();
        imem_req_rdy = 1'b0;
        repeat (rsp_dly) tick();
        check32("rsp_rdy_in_wait", {31'b0, imem_rsp_rdy}, 32'd1);
        imem_rsp_vld  = 1'b1;
        imem_rsp.op   = MEM_READ;
        imem_rsp.addr = m_pc;
        imem_rsp.data = ins;
        model_exec(ins);
        tick();
        imem_rsp_vld  = 1'b0;
        imem_rsp.data = $urandom;
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < 32; i++)
            check32($sformatf("%s_x%0d", name, i), dut.regs[i], m_regs[i]);
    endtask

    task automatic check_reset_outputs();
        check32("rst_req_vld", {31'b0, imem_req_vld}, 32'd0);
        check32("rst_rsp_rdy", {31'b0, imem_rsp_rdy}, 32'd0);
        checks++;
        if (imem_req !== '0) begin
            errors++;
            $display("FAIL rst_req_pkt: got %h expected 0", imem_req);
        end
    endtask

    logic [31:0] dir_prog [13];
    logic [31:0] wrap_prog [3];

    initial begin
        dir_prog = '{32'h00500093, 32'hFFD00113, 32'h002081B3, 32'h12345237,
                     32'h00000463, 32'h00001463, 32'h00700013, 32'h010002EF,
                     32'h04100313, 32'h000303E7, 32'h00002403, 32'h00802023,
                     32'h00030367};
        wrap_prog = '{32'hFFC00513, 32'h00050067, 32'h00000013};
        rst_n = 1'b0;
        imem_req_rdy = 1'b0;
        imem_rsp_vld = 1'b0;
        imem_rsp = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check32("first_req_vld", {31'b0, imem_req_vld}, 32'd1);
        check32("first_rsp_rdy", {31'b0, imem_rsp_rdy}, 32'd0);
        check_regs("reset");
        tick();

        foreach (dir_prog[i]) do_txn(dir_prog[i], (i == 0) ? 2 : 0, 0);
        do_txn(32'h05500493, 5, 4);

        for (int i = 0; i < 300; i++)
            do_txn(rand_instr(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        check_regs("random");

        // reset while waiting for a response that then arrives during/after reset
        wait_req();
        imem_req_rdy = 1'b1;
        tick();
        imem_req_rdy = 1'b0;
        rst_n = 1'b0;
        imem_rsp_vld  = 1'b1;
        imem_rsp.data = 32'h06300093;
        @(negedge clk);
        check_reset_outputs();
        tick();
        model_reset();
        rst_n = 1'b1;
        tick();
        imem_rsp_vld = 1'b0;
        @(negedge clk);
        check_regs("after_wait_reset");
        tick();

        foreach (wrap_prog[i]) do_txn(wrap_prog[i], 0, 1);
        for (int i = 0; i < 30; i++)
            do_txn(rand_instr(), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        wait_req();
        imem_req_rdy = 1'b1;
        tick();
        imem_req_rdy = 1'b0;
        check_regs("final");
        check32("pending_expectations", exp_q.size(), 32'd0);
        finish_sim();
    end

endmodule
